// File: rtl/mtimer_clint_pkg.sv
// Shared definitions for the machine timer / software-interrupt block:
// register offsets, responder states and bus request/response records.
package mtimer_clint_pkg;

    localparam logic [15:0] CLINT_MSIP       = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_L = 16'h4000;
    localparam logic [15:0] CLINT_MTIMECMP_H = 16'h4004;
    localparam logic [15:0] CLINT_MTIME_L    = 16'hBFF8;
    localparam logic [15:0] CLINT_MTIME_H    = 16'hBFFC;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } clint_state_e;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } clint_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } clint_rsp_t;

endpackage

// File: rtl/clint_tick_gen.sv
// Prescaler for mtime: emits a one-cycle tick every TICK_DIV core cycles,
// in the cycle the counter sits at TICK_DIV-1.
module clint_tick_gen #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);

    localparam int unsigned    CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // With TICK_DIV=1 the counter never leaves 0, so the tick is constant high.
    assign tick_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/mtimer_clint.sv
// Machine timer and software-interrupt controller: mtime/mtimecmp/msip
// behind a single-outstanding valid/ready register port.
module mtimer_clint
    import mtimer_clint_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 1,
    parameter logic [63:0] MTIMECMP_RST = '1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [15:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_wstrb_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        sw_irq_o,
    output logic        timer_irq_o,
    output logic [63:0] mtime_o
);

    function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] res;
        res = cur;
        for (int b = 0; b < 4; b++)
            if (wstrb[b]) res[8*b +: 8] = wdata[8*b +: 8];
        return res;
    endfunction

    clint_state_e state_q, state_d;
    clint_rsp_t   rsp_q, rsp_d;
    clint_req_t   req;
    logic [63:0]  mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
    logic         msip_q, msip_d;
    logic         timer_irq_q;
    logic         tick, acc, wr_ok;
    logic         hit_msip, hit_cmp_l, hit_cmp_h, hit_mt_l, hit_mt_h, dec_err;
    logic [63:0]  mtime_inc;
    logic [31:0]  rdata;
    logic [31:0]  m_msip, m_cmp_l, m_cmp_h, m_mt_l, m_mt_h;

    clint_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .tick_o (tick)
    );

    assign req = '{we: req_we_i, addr: req_addr_i, wdata: req_wdata_i, wstrb: req_wstrb_i};

    // Offsets are word aligned, so an exact match also rejects misaligned addresses.
    assign hit_msip  = (req.addr == CLINT_MSIP);
    assign hit_cmp_l = (req.addr == CLINT_MTIMECMP_L);
    assign hit_cmp_h = (req.addr == CLINT_MTIMECMP_H);
    assign hit_mt_l  = (req.addr == CLINT_MTIME_L);
    assign hit_mt_h  = (req.addr == CLINT_MTIME_H);
    assign dec_err   = ~(hit_msip | hit_cmp_l | hit_cmp_h | hit_mt_l | hit_mt_h);

    assign req_ready_o = (state_q == ST_IDLE);
    assign acc         = req_valid_i & req_ready_o;
    assign wr_ok       = acc & req.we & ~dec_err;
    assign mtime_inc   = mtime_q + {63'd0, tick};

    // Written mtime bytes override the incremented value; unwritten ones keep it.
    assign m_msip  = merge_bytes({31'd0, msip_q}, req.wdata, req.wstrb);
    assign m_cmp_l = merge_bytes(mtimecmp_q[31:0],  req.wdata, req.wstrb);
    assign m_cmp_h = merge_bytes(mtimecmp_q[63:32], req.wdata, req.wstrb);
    assign m_mt_l  = merge_bytes(mtime_inc[31:0],   req.wdata, req.wstrb);
    assign m_mt_h  = merge_bytes(mtime_inc[63:32],  req.wdata, req.wstrb);

    always_comb begin
        rdata = '0;
        if (hit_msip)  rdata = {31'd0, msip_q};
        if (hit_cmp_l) rdata = mtimecmp_q[31:0];
        if (hit_cmp_h) rdata = mtimecmp_q[63:32];
        if (hit_mt_l)  rdata = mtime_q[31:0];
        if (hit_mt_h)  rdata = mtime_q[63:32];
    end

    always_comb begin
        state_d    = state_q;
        rsp_d      = rsp_q;
        mtime_d    = mtime_inc;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        case (state_q)
            ST_IDLE: begin
                if (acc) begin
                    state_d     = ST_RESP;
                    rsp_d.err   = dec_err;
                    rsp_d.rdata = (req.we | dec_err) ? 32'd0 : rdata;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (wr_ok) begin
            if (hit_msip)  msip_d            = m_msip[0];
            if (hit_cmp_l) mtimecmp_d[31:0]  = m_cmp_l;
            if (hit_cmp_h) mtimecmp_d[63:32] = m_cmp_h;
            if (hit_mt_l)  mtime_d[31:0]     = m_mt_l;
            if (hit_mt_h)  mtime_d[63:32]    = m_mt_h;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rsp_q       <= '0;
            mtime_q     <= '0;
            mtimecmp_q  <= MTIMECMP_RST;
            msip_q      <= 1'b0;
            timer_irq_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_q       <= rsp_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            msip_q      <= msip_d;
            timer_irq_q <= (mtime_q >= mtimecmp_q);
        end
    end

    assign rsp_valid_o = (state_q == ST_RESP);
    assign rsp_rdata_o = rsp_q.rdata;
    assign rsp_err_o   = rsp_q.err;
    assign sw_irq_o    = msip_q;
    assign timer_irq_o = timer_irq_q;
    assign mtime_o     = mtime_q;

endmodule

// File: tb/tb_mtimer_clint.sv
// Directed bench for mtimer_clint: one instance with TICK_DIV=1 and one with
// TICK_DIV=4, sharing clock, reset and request fields; sel picks the target.
module tb_mtimer_clint;

    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1, sel = 1'b0;
    logic [15:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;

    logic        rdy0, rv0, er0, sw0, ti0, rdy1, rv1, er1, sw1, ti1;
    logic [31:0] rd0, rd1;
    logic [63:0] mt0, mt1;
    logic        c_rdy, c_rv, c_err, c_sw, c_ti;
    logic [31:0] c_rd;

    int n_cmp = 0, n_err = 0, cyc = 0, cyc0 = 0;
    logic [63:0] mbase [2];
    int          mfrom [2];
    logic        post_sw, post_ti;

    mtimer_clint #(.TICK_DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid_i(req_valid & ~sel), .req_ready_o(rdy0),
        .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .req_wstrb_i(req_wstrb), .rsp_valid_o(rv0), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rd0), .rsp_err_o(er0), .sw_irq_o(sw0), .timer_irq_o(ti0),
        .mtime_o(mt0));

    mtimer_clint #(.TICK_DIV(4)) u_dut4 (
        .clk(clk), .rst(rst), .req_valid_i(req_valid & sel), .req_ready_o(rdy1),
        .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .req_wstrb_i(req_wstrb), .rsp_valid_o(rv1), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rd1), .rsp_err_o(er1), .sw_irq_o(sw1), .timer_irq_o(ti1),
        .mtime_o(mt1));

    assign c_rdy = sel ? rdy1 : rdy0;
    assign c_rv  = sel ? rv1  : rv0;
    assign c_err = sel ? er1  : er0;
    assign c_sw  = sel ? sw1  : sw0;
    assign c_ti  = sel ? ti1  : ti0;
    assign c_rd  = sel ? rd1  : rd0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // mtime model: value mbase[k] held from cycle mfrom[k], plus ticks since.
    function automatic logic [63:0] mt_at(input int k, input int c);
        int n = 0;
        int d = (k == 1) ? 4 : 1;
        for (int i = mfrom[k]; i < c; i++)
            if (((i - cyc0) % d) == d - 1) n++;
        return mbase[k] + 64'(n);
    endfunction

    task automatic mwr(input int k, input int a, input logic hi, input logic [31:0] d);
        logic [63:0] m;
        m = mt_at(k, a + 1);
        mbase[k] = hi ? {d, m[31:0]} : {m[63:32], d};
        mfrom[k] = a + 1;
    endtask

    task automatic bus(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input int hold,
                       output logic [31:0] rdata, output logic rerr, output int acc_cyc);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
        while (!c_rdy && n < 20) begin @(negedge clk); n++; end
        chk("req_ready_wait", {63'd0, c_rdy}, 64'd1);
        acc_cyc = cyc;
        if (hold > 0) rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        post_sw = c_sw; post_ti = c_ti;
        @(negedge clk);
        chk("rsp_valid", {63'd0, c_rv}, 64'd1);
        rdata = c_rd; rerr = c_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", {63'd0, c_rv}, 64'd1);
            chk("hold_ready", {63'd0, c_rdy}, 64'd0);
            chk("hold_rdata", {32'd0, c_rd}, {32'd0, rdata});
            chk("hold_err", {63'd0, c_err}, {63'd0, rerr});
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          a, c;
        logic [63:0] m;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {63'd0, rdy0}, 64'd1);
        chk("rst_rsp_valid", {63'd0, rv0}, 64'd0);
        chk("rst_rdata", {32'd0, rd0}, 64'd0);
        chk("rst_err", {63'd0, er0}, 64'd0);
        chk("rst_sw_irq", {63'd0, sw0}, 64'd0);
        chk("rst_timer_irq", {63'd0, ti0}, 64'd0);
        chk("rst_mtime1", mt0, 64'd0);
        chk("rst_mtime4", mt1, 64'd0);
        rst = 1'b0;
        cyc0 = cyc;
        mbase[0] = '0; mbase[1] = '0; mfrom[0] = cyc0; mfrom[1] = cyc0;

        // Accepted in the tenth cycle out of reset: nine ticks have landed.
        repeat (8) @(negedge clk);
        bus(1'b0, 16'hBFF8, '0, '0, 0, rd, er, a);
        chk("mtime_lo_early", {32'd0, rd}, 64'd9);
        chk("mtime_lo_err", {63'd0, er}, 64'd0);
        chk("early_timer_irq", {63'd0, c_ti}, 64'd0);

        bus(1'b1, 16'h0000, 32'h1, 4'hF, 0, rd, er, a);
        chk("msip_set_n1", {63'd0, post_sw}, 64'd1);
        chk("msip_wr_rdata", {32'd0, rd}, 64'd0);
        bus(1'b1, 16'h0000, 32'h0, 4'hF, 0, rd, er, a);
        chk("msip_clr_n1", {63'd0, post_sw}, 64'd0);
        bus(1'b1, 16'h0000, 32'hFFFF_FFFF, 4'hF, 0, rd, er, a);
        bus(1'b0, 16'h0000, '0, '0, 0, rd, er, a);
        chk("msip_readback", {32'd0, rd}, 64'd1);
        chk("msip_sw_irq", {63'd0, c_sw}, 64'd1);

        // Timer compare at 20 with mtime restarted from 0.
        bus(1'b1, 16'h4000, 32'd20, 4'hF, 0, rd, er, a);
        bus(1'b1, 16'hBFF8, 32'd0, 4'hF, 0, rd, er, a);
        mwr(0, a, 1'b0, 32'd0);
        c = a;
        bus(1'b1, 16'h4004, 32'd0, 4'hF, 0, rd, er, a);
        chk("tirq_before", {63'd0, c_ti}, 64'd0);
        do @(negedge clk); while (cyc < c + 21);
        chk("mtime_at_20", mt0, 64'd20);
        chk("tirq_at_20", {63'd0, c_ti}, 64'd0);
        @(negedge clk);
        chk("tirq_after_20", {63'd0, c_ti}, 64'd1);
        bus(1'b1, 16'h4000, 32'hFFFF_FFFF, 4'hF, 0, rd, er, a);
        chk("tirq_lag_n1", {63'd0, post_ti}, 64'd1);
        chk("tirq_dropped", {63'd0, c_ti}, 64'd0);

        // Carry from lo into hi, then full 64-bit wrap.
        bus(1'b1, 16'hBFFC, 32'd0, 4'hF, 0, rd, er, a);
        mwr(0, a, 1'b1, 32'd0);
        bus(1'b1, 16'hBFF8, 32'hFFFF_FFFF, 4'hF, 0, rd, er, a);
        mwr(0, a, 1'b0, 32'hFFFF_FFFF);
        bus(1'b0, 16'hBFFC, '0, '0, 0, rd, er, a);
        chk("carry_hi", {32'd0, rd}, 64'd1);
        bus(1'b0, 16'hBFF8, '0, '0, 0, rd, er, a);
        m = mt_at(0, a);
        chk("carry_lo", {32'd0, rd}, {32'd0, m[31:0]});
        bus(1'b1, 16'hBFFC, 32'hFFFF_FFFF, 4'hF, 0, rd, er, a);
        mwr(0, a, 1'b1, 32'hFFFF_FFFF);
        bus(1'b1, 16'hBFF8, 32'hFFFF_FFFF, 4'hF, 0, rd, er, a);
        mwr(0, a, 1'b0, 32'hFFFF_FFFF);
        bus(1'b0, 16'hBFFC, '0, '0, 0, rd, er, a);
        chk("wrap_hi", {32'd0, rd}, 64'd0);
        bus(1'b0, 16'hBFF8, '0, '0, 0, rd, er, a);
        m = mt_at(0, a);
        chk("wrap_lo", {32'd0, rd}, {32'd0, m[31:0]});

        // TICK_DIV=4 instance.
        sel = 1'b1;
        bus(1'b0, 16'hBFF8, '0, '0, 0, rd, er, a);
        m = mt_at(1, a);
        chk("div4_read1", {32'd0, rd}, {32'd0, m[31:0]});
        repeat (9) @(negedge clk);
        bus(1'b0, 16'hBFF8, '0, '0, 0, rd, er, a);
        m = mt_at(1, a);
        chk("div4_read2", {32'd0, rd}, {32'd0, m[31:0]});
        bus(1'b1, 16'hBFF8, 32'h1234_56FF, 4'hF, 0, rd, er, a);
        mwr(1, a, 1'b0, 32'h1234_56FF);
        @(negedge clk);
        while (((cyc - cyc0) % 4) != 2) @(negedge clk);
        bus(1'b1, 16'hBFF8, 32'h0000_00AB, 4'b0001, 0, rd, er, a);
        m = mt_at(1, a + 1);
        mbase[1] = {m[63:8], 8'hAB};
        mfrom[1] = a + 1;
        bus(1'b0, 16'hBFF8, '0, '0, 0, rd, er, a);
        m = mt_at(1, a);
        chk("byte_merge_lo", {32'd0, rd}, {32'd0, m[31:0]});
        chk("byte_merge_b0", {56'd0, rd[7:0]}, 64'hAB);
        sel = 1'b0;

        // Decode errors leave state alone; stalled response holds steady.
        bus(1'b0, 16'h0002, '0, '0, 0, rd, er, a);
        chk("misalign_err", {63'd0, er}, 64'd1);
        chk("misalign_rdata", {32'd0, rd}, 64'd0);
        bus(1'b1, 16'h0000, 32'h0, 4'hF, 0, rd, er, a);
        bus(1'b1, 16'h0002, 32'hFFFF_FFFF, 4'hF, 0, rd, er, a);
        chk("misalign_wr_err", {63'd0, er}, 64'd1);
        bus(1'b1, 16'h1000, 32'hFFFF_FFFF, 4'hF, 0, rd, er, a);
        chk("unmapped_err", {63'd0, er}, 64'd1);
        chk("unmapped_rdata", {32'd0, rd}, 64'd0);
        bus(1'b0, 16'h1000, '0, '0, 0, rd, er, a);
        chk("unmapped_rd_err", {63'd0, er}, 64'd1);
        bus(1'b0, 16'h0000, '0, '0, 0, rd, er, a);
        chk("msip_untouched", {32'd0, rd}, 64'd0);
        chk("msip_untouched_err", {63'd0, er}, 64'd0);
        bus(1'b1, 16'h0000, 32'h1, 4'h0, 0, rd, er, a);
        chk("wstrb0_ok", {63'd0, er}, 64'd0);
        chk("wstrb0_noop", {63'd0, c_sw}, 64'd0);
        bus(1'b0, 16'h4000, '0, '0, 5, rd, er, a);
        chk("hold_cmp_lo", {32'd0, rd}, 64'hFFFF_FFFF);

        // Reset while a response is pending.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'hBFF8; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", {63'd0, c_rv}, 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_drop_valid", {63'd0, c_rv}, 64'd0);
        chk("rst_drop_ready", {63'd0, c_rdy}, 64'd1);
        chk("rst_drop_rdata", {32'd0, c_rd}, 64'd0);
        chk("rst_drop_mtime", mt0, 64'd0);
        rst = 1'b0; rsp_ready = 1'b1;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
